// File: rtl/ascon_apb_pkg.sv
// Shared register map, bit positions and data types for the ASCON APB front end.
package ascon_apb_pkg;

   // Register indices as decoded from PADDR[4:2]
   localparam logic [2:0] REG_CTRL    = 3'd0;
   localparam logic [2:0] REG_STATUS  = 3'd1;
   localparam logic [2:0] REG_DIN_LO  = 3'd2;
   localparam logic [2:0] REG_DIN_HI  = 3'd3;
   localparam logic [2:0] REG_DOUT_LO = 3'd4;
   localparam logic [2:0] REG_DOUT_HI = 3'd5;
   localparam logic [2:0] REG_IRQ_CLR = 3'd6;
   localparam logic [2:0] REG_RSVD    = 3'd7;

   localparam int CTRL_START_BIT = 4;
   localparam int CTRL_FLUSH_BIT = 5;

   localparam int ST_IN_FULL       = 0;
   localparam int ST_IN_EMPTY      = 1;
   localparam int ST_OUT_NONEMPTY  = 2;
   localparam int ST_CORE_BUSY     = 3;
   localparam int ST_IRQ_PENDING   = 4;
   localparam int ST_IN_COUNT_LSB  = 8;
   localparam int ST_OUT_COUNT_LSB = 12;

   typedef logic [63:0] blk_t;

endpackage

// File: rtl/ascon_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; flush has priority over push and pop.
module ascon_sync_fifo
   import ascon_apb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = $bits(blk_t)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [WIDTH-1:0]         head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             doPush;
   logic             doPop;

   assign full_o  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
   assign empty_o = (wrPtr_q == rdPtr_q);
   assign count_o = wrPtr_q - rdPtr_q;

   // Full/empty are taken before this cycle's pop, so a push into a full FIFO is refused
   assign doPush  = push_i & ~full_o & ~flush_i;
   assign doPop   = pop_i & ~empty_o & ~flush_i;
   assign head_o  = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (flush_i) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
      end else begin
         if (doPush) wrPtr_d = wrPtr_q + 1'b1;
         if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/ascon_apb_frontend.sv
// Zero-wait-state APB slave packing 32-bit writes into 64-bit blocks for the ASCON core
// and buffering core results for readback, with a result-available interrupt.
module ascon_apb_frontend
   import ascon_apb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MODE_W     = 2
) (
   input  logic              clk_in,
   input  logic              reset_int,
   input  logic [31:0]       PADDR,
   input  logic              PENABLE,
   input  logic              PSEL,
   input  logic [31:0]       PWDATA,
   input  logic              PWRITE,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   input  logic              irq_en_1,
   output logic              irq_1,
   output logic [63:0]       blk_data_o,
   output logic              blk_valid_o,
   input  logic              blk_ready_i,
   input  logic [63:0]       res_data_i,
   input  logic              res_valid_i,
   output logic              res_ready_o,
   output logic              core_start_o,
   output logic [MODE_W-1:0] core_mode_o,
   input  logic              core_busy_i
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [2:0]        regIdx;
   logic              access;
   logic              okWrite;
   logic              okRead;
   logic              unusedAddr;

   logic [MODE_W-1:0] mode_q, mode_d;
   logic              start_q, start_d;
   logic [31:0]       dinLo_q, dinLo_d;
   logic              irqPending_q, irqPending_d;
   logic              irqOut_q, irqOut_d;
   logic              ready_q;

   logic              flush;
   logic              inPush, inFull, inEmpty;
   logic [CW-1:0]     inCount;
   blk_t              inHead;
   logic              outPush, outPop, outFull, outEmpty;
   logic [CW-1:0]     outCount;
   blk_t              outHead;
   logic              irqSet, irqClr;
   logic [31:0]       statusWord;

   assign regIdx     = PADDR[4:2];
   assign unusedAddr = ^{PADDR[31:5], PADDR[1:0]};
   assign access     = PSEL & PENABLE;
   assign PREADY     = 1'b1;

   // Error decode; an errored access must leave every register untouched
   always_comb begin
      PSLVERR = 1'b0;
      if (access) begin
         case (regIdx)
            REG_CTRL:    PSLVERR = 1'b0;
            REG_STATUS:  PSLVERR = PWRITE;
            REG_DIN_LO:  PSLVERR = ~PWRITE;
            REG_DIN_HI:  PSLVERR = PWRITE ? inFull : 1'b1;
            REG_DOUT_LO: PSLVERR = PWRITE | outEmpty;
            REG_DOUT_HI: PSLVERR = PWRITE | outEmpty;
            REG_IRQ_CLR: PSLVERR = 1'b0;
            default:     PSLVERR = 1'b1;
         endcase
      end
   end

   assign okWrite = access & PWRITE & ~PSLVERR;
   assign okRead  = access & ~PWRITE & ~PSLVERR;

   always_comb begin
      statusWord                                = '0;
      statusWord[ST_IN_FULL]                    = inFull;
      statusWord[ST_IN_EMPTY]                   = inEmpty;
      statusWord[ST_OUT_NONEMPTY]               = ~outEmpty;
      statusWord[ST_CORE_BUSY]                  = core_busy_i;
      statusWord[ST_IRQ_PENDING]                = irqPending_q;
      statusWord[ST_IN_COUNT_LSB  +: 4]         = 4'(inCount);
      statusWord[ST_OUT_COUNT_LSB +: 4]         = 4'(outCount);
   end

   always_comb begin
      PRDATA = '0;
      if (okRead) begin
         case (regIdx)
            REG_CTRL:    PRDATA[MODE_W-1:0] = mode_q;
            REG_STATUS:  PRDATA = statusWord;
            REG_DOUT_LO: PRDATA = outHead[31:0];
            REG_DOUT_HI: PRDATA = outHead[63:32];
            default:     PRDATA = '0;
         endcase
      end
   end

   assign flush   = okWrite && (regIdx == REG_CTRL) && PWDATA[CTRL_FLUSH_BIT];
   assign inPush  = okWrite && (regIdx == REG_DIN_HI);
   assign outPop  = okRead && (regIdx == REG_DOUT_HI);
   assign outPush = res_valid_i & res_ready_o;

   // A flushed push never lands, so it cannot raise the interrupt
   assign irqSet  = outEmpty & outPush & ~flush;
   assign irqClr  = flush | (okWrite && (regIdx == REG_IRQ_CLR) && PWDATA[0]);

   always_comb begin
      mode_d       = (okWrite && (regIdx == REG_CTRL)) ? PWDATA[MODE_W-1:0] : mode_q;
      start_d      = okWrite && (regIdx == REG_CTRL) && PWDATA[CTRL_START_BIT];
      dinLo_d      = (okWrite && (regIdx == REG_DIN_LO)) ? PWDATA : dinLo_q;
      irqPending_d = irqSet | (irqPending_q & ~irqClr);
      irqOut_d     = irqPending_q & irq_en_1;
   end

   always_ff @(posedge clk_in or negedge reset_int) begin
      if (!reset_int) begin
         mode_q       <= '0;
         start_q      <= 1'b0;
         dinLo_q      <= '0;
         irqPending_q <= 1'b0;
         irqOut_q     <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         start_q      <= start_d;
         dinLo_q      <= dinLo_d;
         irqPending_q <= irqPending_d;
         irqOut_q     <= irqOut_d;
         ready_q      <= 1'b1;
      end
   end

   assign core_mode_o  = mode_q;
   assign core_start_o = start_q;
   assign irq_1        = irqOut_q;
   assign blk_valid_o  = ~inEmpty;
   assign blk_data_o   = inHead;
   assign res_ready_o  = ready_q & ~outFull;

   ascon_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(blk_t))) uInFifo (
      .clk_i   (clk_in),
      .rst_ni  (reset_int),
      .push_i  (inPush),
      .data_i  ({PWDATA, dinLo_q}),
      .pop_i   (blk_valid_o & blk_ready_i),
      .flush_i (flush),
      .full_o  (inFull),
      .empty_o (inEmpty),
      .count_o (inCount),
      .head_o  (inHead)
   );

   ascon_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(blk_t))) uOutFifo (
      .clk_i   (clk_in),
      .rst_ni  (reset_int),
      .push_i  (outPush),
      .data_i  (res_data_i),
      .pop_i   (outPop),
      .flush_i (flush),
      .full_o  (outFull),
      .empty_o (outEmpty),
      .count_o (outCount),
      .head_o  (outHead)
   );

endmodule
